wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 16, max cycles in MEM_WAIT before error (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: instr_valid  input  1  decoded instruction present this cycle.
REQ-005 SHALL have port: is_load  input  1  instruction is a load.
REQ-006 SHALL have port: reg_write  input  1  instruction writes rd.
REQ-007 SHALL have port: rd  input  5  destination register index.
REQ-008 SHALL have port: mem_ready  input  1  data memory returns load data this cycle.
REQ-009 SHALL have port: ld_data  input  32  load data, valid with mem_ready.
REQ-010 SHALL have port: mem_req  output  1  one-cycle load request to data memory.
REQ-011 SHALL have port: stall  output  1  hold PC/decode; instruction not retired.
REQ-012 SHALL have port: result_src  output  1  writeback mux select (0 = ALU, 1 = load data).
REQ-013 SHALL have port: wb_load_data  output  32  registered load data, feeds mux source 2.
REQ-014 SHALL have port: reg_write_en  output  1  register file write enable.
REQ-015 SHALL have port: wb_rd  output  5  register file write index.
REQ-016 SHALL have port: timeout_err  output  1  sticky memory-timeout flag.
REQ-017 SHALL have port: stall_cnt  output  16  count of stalled cycles.

Function
REQ-018 SHALL implement FSM with states IDLE, MEM_WAIT, WB_LOAD, ERR.
REQ-019 SHALL, in IDLE with instr_valid=1 and is_load=0: reg_write_en = reg_write & (rd!=0); result_src=0; wb_rd=rd; stall=0; stay IDLE.
REQ-020 SHALL, in IDLE with instr_valid=1 and is_load=1: mem_req=1 and stall=1 combinationally; latch rd and reg_write; clear wait counter; next state MEM_WAIT.
REQ-021 SHALL ignore mem_ready in IDLE and in the cycle mem_req is asserted.
REQ-022 SHALL, in MEM_WAIT: stall=1; reg_write_en=0; increment wait counter each cycle.
REQ-023 SHALL, in MEM_WAIT with mem_ready=1: capture ld_data into wb_load_data; next state WB_LOAD.
REQ-024 SHALL, in MEM_WAIT with mem_ready=0 and wait counter = MEM_TIMEOUT-1: next state ERR.
REQ-025 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-026 SHALL, in WB_LOAD for exactly one cycle: result_src=1; wb_rd=latched rd; reg_write_en = latched reg_write & (latched rd!=0); stall=0; next state IDLE.
REQ-027 SHALL never assert reg_write_en for rd=0.
REQ-028 SHALL, in ERR: stall=1; timeout_err=1; mem_req=0; reg_write_en=0; leave only by reset.
REQ-029 SHALL hold wb_load_data unchanged except on capture per REQ-023.
REQ-030 SHALL increment stall_cnt on every cycle stall=1, saturating at 0xFFFF.
REQ-031 SHALL drive mem_req=0 in all states other than the IDLE load cycle.
REQ-032 SHALL give a load minimum latency of 3 cycles from presentation to write (IDLE, MEM_WAIT, WB_LOAD).

Reset
REQ-033 SHALL, when rst_n=0 at a rising edge, set state=IDLE, wait counter=0, wb_load_data=0, stall_cnt=0, timeout_err=0, latched rd/reg_write=0.
REQ-034 SHALL, while in reset state IDLE with instr_valid=0, drive mem_req=0, stall=0, reg_write_en=0, result_src=0, wb_rd=0.
REQ-035 SHALL abandon any in-flight load on reset mid-operation (MEM_WAIT/WB_LOAD) with no register write.

Verification
REQ-036 SHALL cover ALU write: instr_valid=1, is_load=0, reg_write=1, rd=5 -> same cycle reg_write_en=1, wb_rd=5, result_src=0, stall=0.
REQ-037 SHALL cover load: rd=7, mem_ready after 2 MEM_WAIT cycles, ld_data=0xDEADBEEF -> mem_req pulse once, stall high 3 cycles, then WB_LOAD with result_src=1, wb_rd=7, wb_load_data=0xDEADBEEF, stall_cnt=3.
REQ-038 SHALL cover rd=0: load to x0 and ALU op to x0 -> reg_write_en never asserted; load still sequences IDLE->MEM_WAIT->WB_LOAD->IDLE.
REQ-039 SHALL cover timeout: MEM_TIMEOUT=4, no mem_ready -> ERR after 4 MEM_WAIT cycles, timeout_err=1, stall held; mem_ready afterwards ignored; rst_n=0 clears.
REQ-040 SHALL cover boundary: mem_ready on the last permitted cycle (counter = MEM_TIMEOUT-1) -> WB_LOAD, not ERR.
REQ-041 SHALL cover reset mid-load: rst_n=0 during MEM_WAIT -> next cycle IDLE, no reg_write_en, stall_cnt=0.

Source files
------------

// File: rtl/wb_ctrl.sv
// Writeback / load-sequencing controller.
// ALU results write back in the cycle they are presented. A load issues a
// one-cycle memory request, waits in MEM_WAIT for mem_ready, and writes the
// registered load data back in a single WB_LOAD cycle. If memory does not
// answer within MEM_TIMEOUT wait cycles the block parks in ERR until reset.
//
// Handshake: mem_req is a single-cycle request pulse with no back-pressure.
// mem_ready/ld_data are accepted only in MEM_WAIT. A ready seen in the
// request cycle, in IDLE, or in ERR is ignored.
module wb_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        is_load,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic        mem_ready,
  input  logic [31:0] ld_data,
  output logic        mem_req,
  output logic        stall,
  output logic        result_src,
  output logic [31:0] wb_load_data,
  output logic        reg_write_en,
  output logic [4:0]  wb_rd,
  output logic        timeout_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB_LOAD  = 2'd2,
    ERR      = 2'd3
  } state_t;

  // Wait counter value of the final MEM_WAIT cycle allowed before timing out.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        load_issue;

  assign load_issue = (state_q == IDLE) && instr_valid && is_load;

  // Next-state and output decode; ready outranks timeout in MEM_WAIT.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    stall        = 1'b0;
    result_src   = 1'b0;
    reg_write_en = 1'b0;
    wb_rd        = 5'd0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (is_load) begin
            mem_req = 1'b1;
            stall   = 1'b1;
            state_d = MEM_WAIT;
          end else begin
            reg_write_en = reg_write && (rd != 5'd0);
            wb_rd        = rd;
          end
        end
      end
      MEM_WAIT: begin
        stall = 1'b1;
        if (mem_ready) begin
          state_d = WB_LOAD;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = ERR;
        end
      end
      WB_LOAD: begin
        result_src   = 1'b1;
        wb_rd        = rd_q;
        reg_write_en = rw_q && (rd_q != 5'd0);
        state_d      = IDLE;
      end
      ERR: begin
        stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A load caught by reset must not write back or start a new request.
    if (!rst_n) begin
      mem_req      = 1'b0;
      reg_write_en = 1'b0;
    end
  end

  // State, load context, captured data, sticky error and stall statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      rd_q         <= 5'd0;
      rw_q         <= 1'b0;
      wb_load_data <= 32'd0;
      timeout_err  <= 1'b0;
      stall_cnt    <= 16'd0;
    end else begin
      state_q <= state_d;
      if (load_issue) begin
        rd_q       <= rd;
        rw_q       <= reg_write;
        wait_cnt_q <= 8'd0;
      end else if (state_q == MEM_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (state_q == MEM_WAIT && mem_ready) begin
        wb_load_data <= ld_data;
      end
      if (state_d == ERR) begin
        timeout_err <= 1'b1;
      end
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus randomized ALU/load traffic,
// each load predicted as a whole transaction (issue, N waits, writeback or
// timeout) from the ready delay chosen for it.
module tb_wb_ctrl;

  localparam int T = 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        instr_valid;
  logic        is_load;
  logic        reg_write;
  logic [4:0]  rd;
  logic        mem_ready;
  logic [31:0] ld_data;
  logic        mem_req;
  logic        stall;
  logic        result_src;
  logic [31:0] wb_load_data;
  logic        reg_write_en;
  logic [4:0]  wb_rd;
  logic        timeout_err;
  logic [15:0] stall_cnt;

  wb_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .is_load      (is_load),
    .reg_write    (reg_write),
    .rd           (rd),
    .mem_ready    (mem_ready),
    .ld_data      (ld_data),
    .mem_req      (mem_req),
    .stall        (stall),
    .result_src   (result_src),
    .wb_load_data (wb_load_data),
    .reg_write_en (reg_write_en),
    .wb_rd        (wb_rd),
    .timeout_err  (timeout_err),
    .stall_cnt    (stall_cnt)
  );

  // Scoreboard state
  int          checks = 0;
  int          failures = 0;
  int          exp_stall = 0;
  logic [31:0] exp_wb = 32'd0;
  logic [31:0] exp_q[$];

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_valid = 1'b0; is_load = 1'b0; reg_write = 1'b0;
    rd = 5'd0; mem_ready = 1'b0; ld_data = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 0;
    exp_wb = 32'd0;
    exp_q.delete();
  endtask

  // One whole load: ready arrives in MEM_WAIT cycle d (1-based); d > T never answers.
  task automatic run_load(input logic [4:0] r, input logic rw, input int d,
                          input logic [31:0] data, input string tag);
    int n;
    n = (d <= T) ? d : T;
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b1; reg_write = rw; rd = r;
    mem_ready = 1'($urandom_range(0, 1)); ld_data = $urandom;
    #1;
    checks++;
    if ({mem_req, stall, reg_write_en, result_src} !== 4'b1100 || stall_cnt !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL %s_issue: req/stall/wen/src=%b cnt=%0d, expected 1100 cnt=%0d",
               tag, {mem_req, stall, reg_write_en, result_src}, stall_cnt, exp_stall);
    end
    exp_stall = (exp_stall < 65535) ? exp_stall + 1 : exp_stall;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      instr_valid = 1'($urandom_range(0, 1)); is_load = 1'($urandom_range(0, 1));
      reg_write = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 31));
      mem_ready = (k == d); ld_data = (k == d) ? data : $urandom;
      #1;
      checks++;
      if ({mem_req, stall, reg_write_en, timeout_err} !== 4'b0100 ||
          stall_cnt !== 16'(exp_stall) || wb_load_data !== exp_wb) begin
        failures++;
        $display("FAIL %s_wait%0d: req/stall/wen/err=%b cnt=%0d data=%h, expected 0100 cnt=%0d data=%h",
                 tag, k, {mem_req, stall, reg_write_en, timeout_err}, stall_cnt, wb_load_data,
                 exp_stall, exp_wb);
      end
      exp_stall = (exp_stall < 65535) ? exp_stall + 1 : exp_stall;
      if (k == d) exp_q.push_back(data);
    end
    if (d <= T) begin
      @(negedge clk);
      instr_valid = 1'b0; is_load = 1'b0; mem_ready = 1'($urandom_range(0, 1)); ld_data = $urandom;
      exp_wb = exp_q.pop_front();
      #1;
      checks++;
      if ({mem_req, stall, result_src, reg_write_en} !== {3'b001, rw && (r != 5'd0)} ||
          wb_rd !== r || wb_load_data !== exp_wb || stall_cnt !== 16'(exp_stall)) begin
        failures++;
        $display("FAIL %s_wb: req/stall/src/wen=%b rd=%0d data=%h cnt=%0d, expected %b rd=%0d data=%h cnt=%0d",
                 tag, {mem_req, stall, result_src, reg_write_en}, wb_rd, wb_load_data, stall_cnt,
                 {3'b001, rw && (r != 5'd0)}, r, exp_wb, exp_stall);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        instr_valid = 1'b1; is_load = 1'($urandom_range(0, 1)); reg_write = 1'b1;
        rd = 5'($urandom_range(1, 31)); mem_ready = 1'b1; ld_data = $urandom;
        #1;
        checks++;
        if ({timeout_err, stall, mem_req, reg_write_en, result_src} !== 5'b11000 ||
            stall_cnt !== 16'(exp_stall) || wb_load_data !== exp_wb) begin
          failures++;
          $display("FAIL %s_err%0d: err/stall/req/wen/src=%b cnt=%0d data=%h, expected 11000 cnt=%0d data=%h",
                   tag, k, {timeout_err, stall, mem_req, reg_write_en, result_src}, stall_cnt,
                   wb_load_data, exp_stall, exp_wb);
        end
        exp_stall = (exp_stall < 65535) ? exp_stall + 1 : exp_stall;
      end
    end
  endtask

  task automatic run_alu(input logic [4:0] r, input logic rw, input string tag);
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b0; reg_write = rw; rd = r;
    mem_ready = 1'($urandom_range(0, 1)); ld_data = $urandom;
    #1;
    checks++;
    if ({mem_req, stall, result_src, reg_write_en} !== {3'b000, rw && (r != 5'd0)} ||
        wb_rd !== r || stall_cnt !== 16'(exp_stall) || wb_load_data !== exp_wb) begin
      failures++;
      $display("FAIL %s: req/stall/src/wen=%b rd=%0d cnt=%0d data=%h, expected %b rd=%0d cnt=%0d data=%h",
               tag, {mem_req, stall, result_src, reg_write_en}, wb_rd, stall_cnt, wb_load_data,
               {3'b000, rw && (r != 5'd0)}, r, exp_stall, exp_wb);
    end
  endtask

  task automatic check_idle(input string tag);
    #1;
    checks++;
    if ({mem_req, stall, reg_write_en, result_src, timeout_err} !== 5'b00000 || wb_rd !== 5'd0 ||
        stall_cnt !== 16'(exp_stall) || wb_load_data !== exp_wb) begin
      failures++;
      $display("FAIL %s: req/stall/wen/src/err=%b rd=%0d cnt=%0d data=%h, expected 00000 rd=0 cnt=%0d data=%h",
               tag, {mem_req, stall, reg_write_en, result_src, timeout_err}, wb_rd, stall_cnt,
               wb_load_data, exp_stall, exp_wb);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    check_idle("reset_state");
  endtask

  task automatic test_alu();
    run_alu(5'd5, 1'b1, "alu_rd5");
    run_alu(5'd0, 1'b1, "alu_rd0");
    run_alu(5'd12, 1'b0, "alu_nowrite");
    run_alu(5'd31, 1'b1, "alu_rd31");
  endtask

  task automatic test_load_basic();
    do_reset();
    run_load(5'd7, 1'b1, 2, 32'hDEADBEEF, "load_basic");
  endtask

  task automatic test_rd0();
    run_load(5'd0, 1'b1, 1, 32'h1234_5678, "load_x0");
    run_alu(5'd0, 1'b1, "alu_x0");
    @(negedge clk);
    instr_valid = 1'b0; mem_ready = 1'b1;
    check_idle("after_x0");
  endtask

  task automatic test_boundary();
    run_load(5'd3, 1'b1, T, 32'hCAFE_F00D, "load_last_cycle");
    run_alu(5'd4, 1'b1, "after_boundary");
  endtask

  task automatic test_timeout();
    do_reset();
    run_load(5'd9, 1'b1, T + 1, 32'd0, "timeout");
    do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    check_idle("timeout_cleared");
    run_load(5'd10, 1'b1, 1, 32'hA5A5_5A5A, "load_after_err");
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b1; reg_write = 1'b1; rd = 5'd9; mem_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0; is_load = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; ld_data = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (reg_write_en !== 1'b0) begin
      failures++;
      $display("FAIL midload_in_reset: wen=%b expected 0", reg_write_en);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    exp_stall = 0; exp_wb = 32'd0; exp_q.delete();
    check_idle("midload_after_reset");
    @(negedge clk);
    check_idle("midload_next");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: run_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand_alu");
        1: run_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), int'($urandom_range(1, T)),
                    $urandom, "rand_load");
        default: begin
          @(negedge clk);
          instr_valid = 1'b0; is_load = 1'($urandom_range(0, 1));
          mem_ready = 1'($urandom_range(0, 1)); ld_data = $urandom;
          check_idle("rand_idle");
        end
      endcase
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sequence and final report
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; is_load = 1'b0; reg_write = 1'b0;
    rd = 5'd0; mem_ready = 1'b0; ld_data = 32'd0;
    test_reset();
    test_alu();
    test_load_basic();
    test_rd0();
    test_boundary();
    test_timeout();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
